// File: rtl/adder_pkg.sv
//==============================================================================
// adder_pkg - FSM state encoding and digit-count helpers for digit_serial_adder
// Revision: 1.0
//==============================================================================
`default_nettype none

package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int ndig(input int width, input int digit);
      return width / digit;
   endfunction

   // A single-digit configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
//==============================================================================
// digit_adder - combinational DIGIT-bit ripple adder built from full-adder cells
// Revision: 1.0
//==============================================================================
`default_nettype none

module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_top
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout  = c[DIGIT];
   // Carry into the top bit; XOR with cout gives signed overflow on the last digit.
   assign c_top = c[DIGIT - 1];

endmodule

`default_nettype wire

// File: rtl/digit_serial_adder.sv
//==============================================================================
// digit_serial_adder - multi-cycle add/sub, DIGIT bits per clock, LSD first
// Revision: 1.0
//==============================================================================
`default_nettype none

module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int             NDIG = ndig(WIDTH, DIGIT);
   localparam int             CW   = cnt_width(NDIG);
   localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

   if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
   end

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             cy;
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0] d_sum;
   logic             d_cout;
   logic             d_ctop;
   logic [WIDTH-1:0] sum_next;

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a     (a_sh[DIGIT-1:0]),
      .b     (b_sh[DIGIT-1:0]),
      .cin   (cy),
      .sum   (d_sum),
      .cout  (d_cout),
      .c_top (d_ctop)
   );

   // New digit enters at the top so the word is LSD-aligned after NDIG shifts.
   assign sum_next = (sum >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         cy       <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  cy    <= sub | cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum  <= sum_next;
               a_sh <= a_sh >> DIGIT;
               b_sh <= b_sh >> DIGIT;
               cy   <= d_cout;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  carry    <= d_cout;
                  overflow <= d_ctop ^ d_cout;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
//==============================================================================
// tb_digit_serial_adder - directed and randomized bench with a behavioural model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_digit_serial_adder;

   localparam int WIDTH = 16;
   localparam int DIGIT = 4;
   localparam int NDIG  = WIDTH / DIGIT;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;
   logic             busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        v;
      int          acc;
   } res_t;

   res_t q[$];

   digit_serial_adder #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Whole-word arithmetic: result, unsigned carry-out and signed overflow.
   function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic ms, input logic mc, input int acc);
      res_t        r;
      logic [15:0] bb;
      logic [16:0] t;
      bb    = ms ? ~mb : mb;
      t     = 17'(ma) + 17'(bb) + 17'(ms ? 1'b1 : mc);
      r.s   = t[15:0];
      r.c   = t[16];
      r.v   = (ma[15] == bb[15]) && (t[15] != ma[15]);
      r.acc = acc;
      return r;
   endfunction

   always @(negedge clk) begin : cmp
      logic eb;
      logic eo;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_sum", sum, 0);
         chk("rst_carry", carry, 0);
         chk("rst_overflow", overflow, 0);
         q.delete();
      end else begin
         eb = (q.size() != 0);
         eo = eb && ((cyc - q[0].acc) >= NDIG);
         chk("in_ready", in_ready, !eb);
         chk("busy", busy, eb);
         chk("out_valid", out_valid, eo);
         if (eo) begin
            chk("model_sum", sum, q[0].s);
            chk("model_carry", carry, q[0].c);
            chk("model_overflow", overflow, q[0].v);
            if (out_ready) void'(q.pop_front());
         end
         if (in_valid && !eb) q.push_back(model(a, b, sub, cin, cyc + 1));
      end
   end

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_wait_in_ready"}, in_ready, 1);
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_wait_out_valid"}, out_valid, 1);
   endtask

   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                        input logic tc, input logic [15:0] es, input logic ec,
                        input logic ev, input string nm);
      a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
      wait_ready(nm);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(nm);
      chk({nm, "_sum"}, sum, es);
      chk({nm, "_carry"}, carry, ec);
      chk({nm, "_overflow"}, overflow, ev);
      @(posedge clk); #1;
   endtask

   logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

   function automatic logic [15:0] pick();
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
      return 16'($urandom);
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
      do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, "add_cin");
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
      do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");

      // Backpressure: result must hold while new requests are refused.
      out_ready = 1'b0;
      a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      wait_ready("bp_first");
      @(posedge clk); #1;
      wait_valid("bp_first");
      for (int k = 0; k < 3; k++) begin
         chk("bp_hold_sum", sum, 16'h2345);
         chk("bp_hold_carry", carry, 0);
         chk("bp_hold_overflow", overflow, 0);
         chk("bp_hold_in_ready", in_ready, 0);
         a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
         @(posedge clk); #1;
      end
      chk("bp_final_sum", sum, 16'h2345);
      a = 16'h2222; b = 16'h0101; sub = 1'b1; cin = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid("bp_second");
      chk("bp_second_sum", sum, 16'h2121);
      chk("bp_second_carry", carry, 1);
      chk("bp_second_overflow", overflow, 0);
      @(posedge clk); #1;

      // Reset after two digits of an operation.
      a = 16'hABCD; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      wait_ready("mid_rst");
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_carry", carry, 0);
      chk("mid_rst_overflow", overflow, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst_add");

      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         a         = pick();
         b         = pick();
         sub       = 1'($urandom);
         cin       = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end

      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_in_ready", in_ready, 1);
      chk("drain_queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
